// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// uart_tx_arbiter
// Shares one byte-wide UART transmitter between NUM_REQ byte-stream
// requesters. Round-robin grant with message locking: a grant is held
// until the requester marks a byte as last, sends MAX_BURST bytes, or
// leaves req_valid low for HOLD_TIMEOUT cycles.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 2,
   parameter int PAYLOAD_BITS = 8,
   parameter int MAX_BURST    = 16,
   parameter int HOLD_TIMEOUT = 255,
   parameter int BUSY_GUARD   = 4,
   localparam int GW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
   input  logic [NUM_REQ-1:0]              req_last,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic                            uart_tx_en,
   output logic [PAYLOAD_BITS-1:0]         uart_tx_data,
   input  logic                            uart_tx_busy,
   output logic [GW-1:0]                   grant_id,
   output logic                            active
);

   localparam int CW = 8;
   // With a transmitter that never raises busy, the launch-to-launch
   // period works out to BUSY_GUARD cycles: one SEND cycle, the
   // LAUNCH_WAIT cycles, and one DONE_WAIT cycle.
   localparam int GUARD_LIMIT = (BUSY_GUARD > 3) ? BUSY_GUARD - 3 : 0;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      SEND        = 2'd1,
      LAUNCH_WAIT = 2'd2,
      DONE_WAIT   = 2'd3
   } state_t;

   state_t                  state;
   logic [GW-1:0]           rr_ptr;
   logic [CW-1:0]           burst_cnt;
   logic [CW-1:0]           hold_cnt;
   logic [CW-1:0]           guard_cnt;
   logic                    last_flag;

   logic [NUM_REQ-1:0]      grant_onehot;
   logic [PAYLOAD_BITS-1:0] req_bytes [NUM_REQ];
   logic [PAYLOAD_BITS-1:0] grant_byte;
   logic                    grant_last;
   logic                    grant_valid;
   logic                    accept;

   logic [2*NUM_REQ-1:0]    valid_dbl;
   logic [NUM_REQ-1:0]      valid_rot;
   logic [GW:0]             pick_offset;
   logic [GW:0]             pick_sum;
   logic                    pick_found;
   logic [GW-1:0]           pick_idx;
   logic [GW-1:0]           release_ptr;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign grant_onehot[gi] = (grant_id == GW'(gi));
         assign req_bytes[gi]    = req_data[gi*PAYLOAD_BITS +: PAYLOAD_BITS];
         // Ready only for the granted requester, and never while the
         // transmitter is still busy, so a launch cannot collide with busy.
         assign req_ready[gi]    = (state == SEND) && grant_onehot[gi] && !uart_tx_busy;
      end
   endgenerate

   assign grant_valid = |(req_valid & grant_onehot);
   assign accept      = |(req_valid & req_ready);
   assign active      = (state != IDLE);
   assign release_ptr = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

   // Select byte and last flag of the granted requester.
   always_comb begin
      grant_byte = '0;
      grant_last = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_onehot[k]) begin
            grant_byte = req_bytes[k];
            grant_last = req_last[k];
         end
      end
   end

   // Round-robin search: rotate the valid vector so rr_ptr sits at bit 0,
   // take the lowest set bit, then map the offset back to a requester id.
   always_comb begin
      valid_dbl   = {req_valid, req_valid};
      valid_rot   = valid_dbl[rr_ptr +: NUM_REQ];
      pick_found  = |valid_rot;
      pick_offset = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (valid_rot[k]) pick_offset = (GW+1)'(k);
      end
      pick_sum = {1'b0, rr_ptr} + pick_offset;
      if (pick_sum >= (GW+1)'(NUM_REQ)) pick_sum = pick_sum - (GW+1)'(NUM_REQ);
      pick_idx = pick_sum[GW-1:0];
   end

   // Arbitration FSM with registered launch pulse, data and grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         uart_tx_en   <= 1'b0;
         uart_tx_data <= '0;
         grant_id     <= '0;
         rr_ptr       <= '0;
         burst_cnt    <= '0;
         hold_cnt     <= '0;
         guard_cnt    <= '0;
         last_flag    <= 1'b0;
      end else begin
         uart_tx_en <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant_id  <= pick_idx;
                  burst_cnt <= '0;
                  hold_cnt  <= '0;
                  state     <= SEND;
               end
            end
            SEND: begin
               if (accept) begin
                  uart_tx_data <= grant_byte;
                  uart_tx_en   <= 1'b1;
                  burst_cnt    <= burst_cnt + 1'b1;
                  last_flag    <= grant_last;
                  hold_cnt     <= '0;
                  guard_cnt    <= '0;
                  state        <= LAUNCH_WAIT;
               end else if (!grant_valid) begin
                  // An idle holder gets HOLD_TIMEOUT cycles before losing the grant.
                  if (hold_cnt == CW'(HOLD_TIMEOUT - 1)) begin
                     hold_cnt <= '0;
                     rr_ptr   <= release_ptr;
                     state    <= IDLE;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
            end
            LAUNCH_WAIT: begin
               // A transmitter that never acknowledges must not stall the arbiter.
               if (uart_tx_busy || guard_cnt == CW'(GUARD_LIMIT)) begin
                  state <= DONE_WAIT;
               end else begin
                  guard_cnt <= guard_cnt + 1'b1;
               end
            end
            DONE_WAIT: begin
               if (!uart_tx_busy) begin
                  if (last_flag || burst_cnt == CW'(MAX_BURST)) begin
                     rr_ptr <= release_ptr;
                     state  <= IDLE;
                  end else begin
                     state  <= SEND;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
